dmem_responder: RTL and testbench

Target-side data-memory responder for the pipelined RISC-V core. It sits behind the MEM stage's load/store port and accepts one word request at a time over a valid/ready handshake. After a configurable number of wait states it returns read data or a write acknowledgement over a second valid/ready handshake. It lets the core be exercised against a multi-cycle memory instead of a zero-latency combinational array.

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_array.sv | 41 ++++
 rtl/dmem_responder.sv | 141 ++++++++++++++
 tb/tb_dmem_responder.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder.
// Byte strobes are honoured only when DMEM_WSTRB_EN is defined.
package dmem_pkg;

   localparam int DMEM_DATA_W = 32;
   localparam int DMEM_STRB_W = 4;
   localparam int DMEM_CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port word array with per-byte write enable, async read,
// and asynchronous clear of every word.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH = 256
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     we,
   input  logic [DMEM_STRB_W-1:0]   be,
   input  logic [$clog2(DEPTH)-1:0] idx,
   input  logic [DMEM_DATA_W-1:0]   wdata,
   output logic [DMEM_DATA_W-1:0]   rdata
);

   logic [DMEM_DATA_W-1:0] mem_q [DEPTH];
   logic [DMEM_DATA_W-1:0] word_d;

   always_comb begin
      word_d = mem_q[idx];
      for (int b = 0; b < DMEM_STRB_W; b++) begin
         if (be[b]) begin
            word_d[8*b +: 8] = wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we) begin
         mem_q[idx] <= word_d;
      end
   end

   assign rdata = mem_q[idx];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory target with valid/ready request and response.
// Define DMEM_WSTRB_EN to add the req_wstrb byte-strobe port.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_STATES = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_we,
   input  logic [31:0]            req_addr,
   input  logic [DMEM_DATA_W-1:0] req_wdata,
`ifdef DMEM_WSTRB_EN
   input  logic [DMEM_STRB_W-1:0] req_wstrb,
`endif
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [DMEM_DATA_W-1:0] rsp_rdata,
   output logic                   rsp_err
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
   localparam logic [DMEM_CNT_W-1:0] CNT_INIT =
      DMEM_CNT_W'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

   state_e                 state_q, state_d;
   logic [DMEM_CNT_W-1:0]  cnt_q, cnt_d;
   logic                   we_q, we_d;
   logic [31:0]            addr_q, addr_d;
   logic [DMEM_DATA_W-1:0] wdata_q, wdata_d;
   logic [DMEM_STRB_W-1:0] strb_q, strb_d;
   logic [DMEM_STRB_W-1:0] req_strb;
   logic                   rsp_valid_q, rsp_valid_d;
   logic                   rsp_err_q, rsp_err_d;
   logic [DMEM_DATA_W-1:0] rdata_q, rdata_d;

   logic                   bad;
   logic                   arr_we;
   logic [DMEM_DATA_W-1:0] arr_rdata;

`ifdef DMEM_WSTRB_EN
   assign req_strb = req_wstrb;
`else
   assign req_strb = '1;
`endif

   assign bad = (addr_q[1:0] != 2'b00) ||
                ({1'b0, addr_q} >= ADDR_LIMIT);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      strb_d      = strb_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rdata_d     = rdata_q;
      arr_we      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               strb_d  = req_strb;
               if (WAIT_STATES == 0) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) state_d = RESP;
            else             cnt_d   = cnt_q - 1'b1;
         end
         RESP: begin
            // First RESP cycle performs the access; valid follows it.
            if (!rsp_valid_q) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = bad;
               rdata_d     = (bad || we_q) ? '0 : arr_rdata;
               arr_we      = we_q && !bad;
            end else if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         strb_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         strb_q      <= strb_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rdata_q     <= rdata_d;
      end
   end

   dmem_array #(
      .DEPTH (DEPTH_WORDS)
   ) u_array (
      .clk   (clk),
      .rst_n (reset),
      .we    (arr_we),
      .be    (strb_q),
      .idx   (addr_q[AW+1:2]),
      .wdata (wdata_q),
      .rdata (arr_rdata)
   );

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised self-checking bench for dmem_responder against a word-level model.
// Byte-strobe scenarios are included when DMEM_WSTRB_EN is defined.
module tb_dmem_responder;

   localparam int DEPTH = 256;
   localparam int WS    = 2;
   localparam int TMO   = 50;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_wstrb = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int checks = 0;
   int failures = 0;

   logic [31:0] model_mem [DEPTH];

   always #5 clk = ~clk;

   dmem_responder #(
      .DEPTH_WORDS (DEPTH),
      .WAIT_STATES (WS)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
`ifdef DMEM_WSTRB_EN
      .req_wstrb (req_wstrb),
`endif
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   function automatic void model_clear();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
   endfunction

   // Word-level view of the memory: what a load/store should return.
   function automatic void model_access(input logic we, input logic [31:0] addr,
                                        input logic [31:0] wdata, input logic [3:0] strb,
                                        output logic [31:0] rd, output logic er);
      logic [3:0] s;
`ifdef DMEM_WSTRB_EN
      s = strb;
`else
      s = 4'hF;
`endif
      er = (addr % 4 != 0) || (longint'(addr) >= longint'(4 * DEPTH));
      rd = 32'h0;
      if (!er) begin
         if (we) begin
            for (int b = 0; b < 4; b++)
               if (s[b]) model_mem[addr / 4][8*b +: 8] = wdata[8*b +: 8];
         end else begin
            rd = model_mem[addr / 4];
         end
      end
   endfunction

   // One transaction; hold = cycles rsp_ready stays low once valid is seen.
   task automatic do_req(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input int hold,
                         output logic [31:0] rd, output logic er, output int lat,
                         output bit stable, output logic vld_after,
                         output logic rdy_after);
      int n;
      n = 0;
      rsp_ready = (hold == 0);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_wstrb = strb;
      while (!req_ready && n < TMO) begin
         @(posedge clk); #1; n++;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < TMO) begin
         @(posedge clk); #1; lat++;
      end
      rd = rsp_rdata;
      er = rsp_err;
      stable = 1'b1;
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_err !== er ||
             req_ready !== 1'b0) stable = 1'b0;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      vld_after = rsp_valid;
      rdy_after = req_ready;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         failures++; $display("FAIL reset_req_ready got=%b want=1", req_ready);
      end
      checks++;
      if (rsp_valid !== 1'b0) begin
         failures++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid);
      end
      checks++;
      if (rsp_rdata !== 32'h0) begin
         failures++; $display("FAIL reset_rsp_rdata got=%h want=0", rsp_rdata);
      end
      checks++;
      if (rsp_err !== 1'b0) begin
         failures++; $display("FAIL reset_rsp_err got=%b want=0", rsp_err);
      end
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_first_load();
      logic [31:0] rd, erd; logic er, eer; int lat; bit st; logic va, ra;
      model_access(1'b0, 32'h10, 32'h0, 4'h0, erd, eer);
      do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, st, va, ra);
      checks++;
      if (lat !== WS + 1) begin
         failures++; $display("FAIL first_load_latency got=%0d want=%0d", lat, WS + 1);
      end
      checks++;
      if (rd !== erd || er !== eer) begin
         failures++;
         $display("FAIL first_load_data got=%h/%b want=%h/%b", rd, er, erd, eer);
      end
   endtask

   task automatic test_store_load();
      logic [31:0] rd, erd; logic er, eer; int lat; bit st; logic va, ra;
      model_access(1'b1, 32'h20, 32'hDEADBEEF, 4'hF, erd, eer);
      do_req(1'b1, 32'h20, 32'hDEADBEEF, 4'hF, 0, rd, er, lat, st, va, ra);
      checks++;
      if (rd !== erd || er !== eer) begin
         failures++;
         $display("FAIL store_rsp got=%h/%b want=%h/%b", rd, er, erd, eer);
      end
      model_access(1'b0, 32'h20, 32'h0, 4'h0, erd, eer);
      do_req(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, st, va, ra);
      checks++;
      if (rd !== 32'hDEADBEEF || rd !== erd || er !== 1'b0) begin
         failures++;
         $display("FAIL store_load got=%h/%b want=%h/0", rd, er, erd);
      end
   endtask

   task automatic test_errors();
      logic [31:0] rd, erd; logic er, eer; int lat; bit st; logic va, ra;
      logic [31:0] addrs [3];
      addrs[0] = 32'h22;
      addrs[1] = 32'(4 * DEPTH);
      addrs[2] = 32'h20;
      for (int i = 0; i < 3; i++) begin
         model_access(1'b0, addrs[i], 32'h0, 4'h0, erd, eer);
         do_req(1'b0, addrs[i], 32'h0, 4'h0, 0, rd, er, lat, st, va, ra);
         checks++;
         if (rd !== erd || er !== eer) begin
            failures++;
            $display("FAIL err_load addr=%h got=%h/%b want=%h/%b",
                     addrs[i], rd, er, erd, eer);
         end
      end
      // Misaligned store must not touch the array.
      model_access(1'b1, 32'h21, 32'h11111111, 4'hF, erd, eer);
      do_req(1'b1, 32'h21, 32'h11111111, 4'hF, 0, rd, er, lat, st, va, ra);
      checks++;
      if (er !== 1'b1 || rd !== 32'h0) begin
         failures++; $display("FAIL err_store got=%h/%b want=0/1", rd, er);
      end
   endtask

   task automatic test_stall();
      logic [31:0] rd, erd; logic er, eer; int lat; bit st; logic va, ra;
      model_access(1'b0, 32'h20, 32'h0, 4'h0, erd, eer);
      do_req(1'b0, 32'h20, 32'h0, 4'h0, 5, rd, er, lat, st, va, ra);
      checks++;
      if (st !== 1'b1) begin
         failures++; $display("FAIL stall_stable got=%b want=1", st);
      end
      checks++;
      if (rd !== erd || er !== eer) begin
         failures++; $display("FAIL stall_data got=%h/%b want=%h/%b", rd, er, erd, eer);
      end
      checks++;
      if (va !== 1'b0 || ra !== 1'b1) begin
         failures++; $display("FAIL stall_release got=v%b/r%b want=v0/r1", va, ra);
      end
   endtask

   task automatic test_reset_mid_wait();
      logic [31:0] rd, erd; logic er, eer; int lat; bit st; logic va, ra;
      bit seen;
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'h40;
      req_wdata = 32'h12345678;
      req_wstrb = 4'hF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #2;
      reset = 1'b0;
      model_clear();
      #11;
      reset = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (rsp_valid) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         failures++; $display("FAIL reset_mid_wait_rsp got=%b want=0", seen);
      end
      model_access(1'b0, 32'h40, 32'h0, 4'h0, erd, eer);
      do_req(1'b0, 32'h40, 32'h0, 4'h0, 0, rd, er, lat, st, va, ra);
      checks++;
      if (rd !== 32'h0 || rd !== erd || er !== eer) begin
         failures++; $display("FAIL reset_mid_wait_load got=%h/%b want=0/0", rd, er);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd, erd; logic er, eer; int lat; bit st; logic va, ra;
      logic [31:0] a, d;
      for (int i = 0; i < 4; i++) begin
         a = {22'h0, 8'(i * 3), 2'b00};
         d = $urandom;
         model_access(i[0], a, d, 4'hF, erd, eer);
         do_req(i[0], a, d, 4'hF, 0, rd, er, lat, st, va, ra);
         checks++;
         if (lat !== WS + 1 || ra !== 1'b1 || va !== 1'b0 ||
             rd !== erd || er !== eer) begin
            failures++;
            $display("FAIL b2b[%0d] lat=%0d rdy=%b vld=%b got=%h/%b want=%h/%b",
                     i, lat, ra, va, rd, er, erd, eer);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] rd, erd; logic er, eer; int lat; bit st; logic va, ra;
      logic [31:0] a, d; logic w; logic [3:0] s; int hold; int sel;
      for (int i = 0; i < 60; i++) begin
         sel = $urandom_range(0, 9);
         if (sel < 7)       a = {$urandom_range(0, 15), 2'b00};
         else if (sel == 7) a = {$urandom_range(0, 255), 2'b00} | 32'($urandom_range(1, 3));
         else if (sel == 8) a = 32'(4 * DEPTH) + {$urandom_range(0, 255), 2'b00};
         else               a = $urandom;
         w    = $urandom_range(0, 1);
         d    = $urandom;
         s    = 4'($urandom_range(0, 15));
         hold = $urandom_range(0, 2);
         model_access(w, a, d, s, erd, eer);
         do_req(w, a, d, s, hold, rd, er, lat, st, va, ra);
         checks++;
         if (rd !== erd || er !== eer || lat !== WS + 1 || st !== 1'b1 ||
             va !== 1'b0 || ra !== 1'b1) begin
            failures++;
            $display("FAIL random[%0d] we=%b addr=%h got=%h/%b lat=%0d want=%h/%b lat=%0d",
                     i, w, a, rd, er, lat, erd, eer, WS + 1);
         end
      end
   endtask

`ifdef DMEM_WSTRB_EN
   task automatic test_wstrb();
      logic [31:0] rd, erd; logic er, eer; int lat; bit st; logic va, ra;
      model_access(1'b1, 32'h30, 32'hFFFFFFFF, 4'hF, erd, eer);
      do_req(1'b1, 32'h30, 32'hFFFFFFFF, 4'hF, 0, rd, er, lat, st, va, ra);
      model_access(1'b1, 32'h30, 32'h000000AA, 4'b0001, erd, eer);
      do_req(1'b1, 32'h30, 32'h000000AA, 4'b0001, 0, rd, er, lat, st, va, ra);
      model_access(1'b0, 32'h30, 32'h0, 4'h0, erd, eer);
      do_req(1'b0, 32'h30, 32'h0, 4'h0, 0, rd, er, lat, st, va, ra);
      checks++;
      if (rd !== 32'hFFFFFFAA || rd !== erd || er !== 1'b0) begin
         failures++; $display("FAIL wstrb_byte0 got=%h want=ffffffaa", rd);
      end
      model_access(1'b1, 32'h30, 32'h12345678, 4'b0000, erd, eer);
      do_req(1'b1, 32'h30, 32'h12345678, 4'b0000, 0, rd, er, lat, st, va, ra);
      checks++;
      if (er !== 1'b0 || lat !== WS + 1) begin
         failures++; $display("FAIL wstrb_zero_rsp err=%b lat=%0d want=0/%0d", er, lat, WS + 1);
      end
      model_access(1'b0, 32'h30, 32'h0, 4'h0, erd, eer);
      do_req(1'b0, 32'h30, 32'h0, 4'h0, 0, rd, er, lat, st, va, ra);
      checks++;
      if (rd !== 32'hFFFFFFAA || rd !== erd) begin
         failures++; $display("FAIL wstrb_zero_keep got=%h want=ffffffaa", rd);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_first_load();
      test_store_load();
      test_errors();
      test_stall();
      test_reset_mid_wait();
      test_back_to_back();
`ifdef DMEM_WSTRB_EN
      test_wstrb();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
